conv_pe_stream: RTL and testbench
=================================

CONV_PE_STREAM -- requirements
Module: conv_pe_stream

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, square kernel edge K (>=1).
REQ-002 SHALL have parameter FM_SIZE, default 5, square input feature-map edge N (>=K).
REQ-003 SHALL have parameter STRIDE, default 1, window step S; (N-K) SHALL be divisible by S.
REQ-004 SHALL have parameter DATA_W, default 30; WEIGHT_W, default 18; ACC_W, default 48.
REQ-005 i_clk  in  1  sole clock, all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_en  in  1  pixel-valid strobe.
REQ-008 i_DataFM  in  DATA_W signed  pixel, raster order, row-major.
REQ-009 i_Weight  in  K*K*WEIGHT_W signed  kernel, element (r,c) at slice index r*K+c, LSB-first.
REQ-010 i_Bias  in  ACC_W signed  bias added to every output.
REQ-011 i_relu  in  1  1 = clamp negative results to 0.
REQ-012 o_ready  out  1  block accepts a pixel this cycle.
REQ-013 o_en  out  1  o_P valid strobe.
REQ-014 o_P  out  ACC_W signed  convolution result.
REQ-015 o_frame_done  out  1  one-cycle pulse coincident with the last o_en of a frame.

Function
REQ-016 Pixel accepted only when i_en=1 and o_ready=1; otherwise i_DataFM is ignored.
REQ-017 FSM states IDLE, STREAM, DRAIN; o_ready=1 in IDLE and STREAM, 0 in DRAIN.
REQ-018 IDLE->STREAM on first accepted pixel; STREAM->DRAIN on acceptance of pixel N*N; DRAIN->IDLE after the last output emerges (3 cycles).
REQ-019 i_Weight, i_Bias, i_relu SHALL be latched on first accepted pixel of a frame and held for that frame.
REQ-020 K-1 line buffers of N pixels plus a KxK window register SHALL form the sliding window; no padding.
REQ-021 Row/column counters SHALL advance per accepted pixel only; column wraps at N-1, row wraps at N-1 to 0.
REQ-022 A window is valid when accepted pixel (row,col) has row>=K-1, col>=K-1, (row-K+1) mod S=0, (col-K+1) mod S=0.
REQ-023 Outputs per frame SHALL be ((N-K)/S+1)^2, in raster order of window top-left corner.
REQ-024 Result = sum over r,c of window(r,c)*weight(r,c) + bias, two's complement, ACC_W bits, wraps on overflow.
REQ-025 If latched relu=1 and result<0, o_P SHALL be 0.
REQ-026 Pipeline: stage 1 registered products, stage 2 registered adder-tree sum plus bias, stage 3 registered ReLU/output.
REQ-027 o_en SHALL assert exactly 3 cycles after the accepting cycle of a window-completing pixel; gaps in i_en propagate unchanged.
REQ-028 o_P SHALL hold its last value while o_en=0.
REQ-029 K=1 SHALL degenerate to per-pixel multiply+bias with no line buffers.

Reset
REQ-030 i_rst=1 at a clock edge SHALL force FSM IDLE, counters 0, pipeline valid bits 0, o_en=0, o_P=0, o_frame_done=0, o_ready=1 next cycle.
REQ-031 Reset mid-frame SHALL discard the partial frame; line-buffer contents need not be cleared.
REQ-032 i_rst SHALL take priority over i_en in the same cycle.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, pipeline latency constant (3), and output-count function.
REQ-034 Line buffer SHALL be a sub-module line_buffer (depth N, width DATA_W, shift on enable).

Verification
REQ-035 K=3,N=5,S=1, weights all 1, bias 0, pixels 1..25 -> o_P 63,72,81,108,117,126,153,162,171; first o_en 3 cycles after pixel 13 accepted; o_frame_done with 171.
REQ-036 Same with S=2 -> exactly 4 outputs 63,81,153,171.
REQ-037 Weights all 1, bias -100, relu=1 -> 0,0,0,8,17,26,53,62,71; weights all -1, relu=0 -> -63..-171.
REQ-038 i_en asserted every other cycle, pixels 1..25 -> same 9 values, o_en spacing 2 cycles within rows.
REQ-039 i_rst for one cycle after pixel 10 -> o_en=0, o_P=0; new frame 1..25 -> REQ-035 sequence exactly.
REQ-040 Two back-to-back frames with i_en held 1 -> o_ready low 3 cycles after pixel 25, second frame outputs identical to first.

Source files
------------

// File: rtl/conv_pe_stream_pkg.sv
// Shared definitions for the streaming convolution PE: FSM encoding,
// pipeline depth and the per-frame output count.
package conv_pe_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } pe_state_e;

  // Products -> adder tree + bias -> ReLU/output register.
  localparam int unsigned PIPE_LAT = 32'd3;

  // Number of windows produced by one N x N frame with a K x K kernel and step S.
  function automatic int unsigned out_count(input int unsigned n,
                                            input int unsigned k,
                                            input int unsigned s);
    int unsigned per_dim;
    per_dim = (n - k) / s + 32'd1;
    return per_dim * per_dim;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One feature-map row of delay: dout is the sample shifted in DEPTH enables ago.
module line_buffer #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    shift_en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] mem_r [DEPTH];

  // Advance one position per accepted pixel; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/conv_pe_stream.sv
// Streaming K x K convolution processing element: raster pixels in, one
// bias-added (optionally ReLU-clamped) result per valid window out.
module conv_pe_stream
  import conv_pe_stream_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 5,
  parameter int STRIDE      = 1,
  parameter int DATA_W      = 30,
  parameter int WEIGHT_W    = 18,
  parameter int ACC_W       = 48
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic                                          i_en,
  input  logic signed [DATA_W-1:0]                      i_DataFM,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0]   i_Weight,
  input  logic signed [ACC_W-1:0]                       i_Bias,
  input  logic                                          i_relu,
  output logic                                          o_ready,
  output logic                                          o_en,
  output logic signed [ACC_W-1:0]                       o_P,
  output logic                                          o_frame_done
);

  localparam int K     = KERNEL_SIZE;
  localparam int N     = FM_SIZE;
  localparam int KK    = K * K;
  localparam int S_EFF = (N == K) ? 32'sd1 : STRIDE;
  localparam int CNT_W = (N > 32'sd1) ? $clog2(N) : 32'sd1;
  localparam int OUT_N = int'(out_count(N, K, STRIDE));
  localparam int OUT_W = (OUT_N > 32'sd1) ? $clog2(OUT_N) : 32'sd1;

  pe_state_e               state_r;
  logic [1:0]              drain_cnt_r;
  logic                    accept_s;
  logic                    last_pix_s;
  logic                    win_hit_s;
  logic [CNT_W-1:0]        row_r;
  logic [CNT_W-1:0]        col_r;
  logic [OUT_W-1:0]        win_idx_r;

  logic signed [WEIGHT_W-1:0] w_r [KK];
  logic signed [ACC_W-1:0]    bias_r;
  logic                       relu_r;

  logic signed [DATA_W-1:0] lb_tap_s [K];
  logic signed [DATA_W-1:0] win_r    [K][K];
  logic                     win_vld_r;
  logic                     win_last_r;

  logic signed [ACC_W-1:0]  prod_r [KK];
  logic                     p_vld_r;
  logic                     p_last_r;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  sum_r;
  logic                     s_vld_r;
  logic                     s_last_r;

  assign accept_s   = i_en & o_ready;
  assign last_pix_s = (row_r == CNT_W'(N - 32'sd1)) && (col_r == CNT_W'(N - 32'sd1));
  assign win_hit_s  = accept_s
                    && (int'(row_r) >= K - 32'sd1) && (int'(col_r) >= K - 32'sd1)
                    && (((int'(row_r) - (K - 32'sd1)) % S_EFF) == 32'sd0)
                    && (((int'(col_r) - (K - 32'sd1)) % S_EFF) == 32'sd0);

  // Frame sequencing; o_ready drops for the pipeline drain after the last pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 2'd0;
      o_ready     <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          drain_cnt_r <= 2'd0;
          if (accept_s) begin
            state_r <= last_pix_s ? ST_DRAIN : ST_STREAM;
            o_ready <= ~last_pix_s;
          end
        end
        ST_STREAM: begin
          drain_cnt_r <= 2'd0;
          if (accept_s && last_pix_s) begin
            state_r <= ST_DRAIN;
            o_ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == 2'(PIPE_LAT - 32'd1)) begin
            state_r     <= ST_IDLE;
            o_ready     <= 1'b1;
            drain_cnt_r <= 2'd0;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          drain_cnt_r <= 2'd0;
          o_ready     <= 1'b1;
        end
      endcase
    end
  end

  // Raster position of the next pixel plus the running window index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_r      <= '0;
      col_r      <= '0;
      win_idx_r  <= '0;
      win_vld_r  <= 1'b0;
      win_last_r <= 1'b0;
    end else begin
      win_vld_r  <= win_hit_s;
      win_last_r <= win_hit_s && (win_idx_r == OUT_W'(OUT_N - 32'sd1));
      if (win_hit_s) begin
        win_idx_r <= (win_idx_r == OUT_W'(OUT_N - 32'sd1)) ? '0 : win_idx_r + OUT_W'(1);
      end
      if (accept_s) begin
        if (col_r == CNT_W'(N - 32'sd1)) begin
          col_r <= '0;
          row_r <= (row_r == CNT_W'(N - 32'sd1)) ? '0 : row_r + CNT_W'(1);
        end else begin
          col_r <= col_r + CNT_W'(1);
        end
      end
    end
  end

  // Kernel, bias and ReLU mode are frozen at the first pixel of each frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bias_r <= '0;
      relu_r <= 1'b0;
      for (int i = 0; i < KK; i++) w_r[i] <= '0;
    end else if (accept_s && (state_r == ST_IDLE)) begin
      bias_r <= i_Bias;
      relu_r <= i_relu;
      for (int i = 0; i < KK; i++) w_r[i] <= i_Weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Row j of the window column comes from j line buffers back; K=1 needs none.
  assign lb_tap_s[0] = i_DataFM;
  for (genvar j = 1; j < K; j++) begin : g_lb
    line_buffer #(.DEPTH(N), .WIDTH(DATA_W)) u_line_buffer (
      .clk      (i_clk),
      .shift_en (accept_s),
      .din      (lb_tap_s[j-1]),
      .dout     (lb_tap_s[j])
    );
  end

  // Window slides left by one column per pixel; newest column enters at K-1.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_r[r][c] <= win_r[r][c+1];
        win_r[r][K-1] <= lb_tap_s[K-1-r];
      end
    end
  end

  // Stage 1: per-tap products, wrapped to the accumulator width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_vld_r  <= 1'b0;
      p_last_r <= 1'b0;
    end else begin
      p_vld_r  <= win_vld_r;
      p_last_r <= win_last_r;
    end
    if (win_vld_r) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          prod_r[r*K+c] <= ACC_W'(win_r[r][c]) * ACC_W'(w_r[r*K+c]);
        end
      end
    end
  end

  // Adder tree over all taps.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < KK; i++) sum_s = sum_s + prod_r[i];
  end

  // Stage 2: registered sum plus bias.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_vld_r  <= 1'b0;
      s_last_r <= 1'b0;
    end else begin
      s_vld_r  <= p_vld_r;
      s_last_r <= p_last_r;
    end
    if (p_vld_r) sum_r <= sum_s + bias_r;
  end

  // Stage 3: ReLU and output register; o_P holds between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en         <= 1'b0;
      o_frame_done <= 1'b0;
      o_P          <= '0;
    end else begin
      o_en         <= s_vld_r;
      o_frame_done <= s_vld_r & s_last_r;
      if (s_vld_r) o_P <= (relu_r && sum_r[ACC_W-1]) ? '0 : sum_r;
    end
  end

endmodule

// File: tb/tb_conv_pe_stream.sv
// Bench for conv_pe_stream: stride-1 and stride-2 instances on shared stimulus,
// checked against a window-by-window arithmetic model of the convolution.
module tb_conv_pe_stream;

  localparam int K = 3, N = 5, NN = N * N, KK = K * K;
  localparam int DATA_W = 30, WEIGHT_W = 18, ACC_W = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, relu;
  logic signed [DATA_W-1:0]  data;
  logic [KK*WEIGHT_W-1:0]    weight;
  logic signed [ACC_W-1:0]   bias;
  logic rdy [2], oen [2], done [2];
  logic signed [ACC_W-1:0]   p [2];

  conv_pe_stream #(.KERNEL_SIZE(K), .FM_SIZE(N), .STRIDE(1)) dut_s1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_DataFM(data), .i_Weight(weight),
    .i_Bias(bias), .i_relu(relu), .o_ready(rdy[0]), .o_en(oen[0]), .o_P(p[0]),
    .o_frame_done(done[0]));

  conv_pe_stream #(.KERNEL_SIZE(K), .FM_SIZE(N), .STRIDE(2)) dut_s2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_DataFM(data), .i_Weight(weight),
    .i_Bias(bias), .i_relu(relu), .o_ready(rdy[1]), .o_en(oen[1]), .o_P(p[1]),
    .o_frame_done(done[1]));

  int n_cmp = 0, n_bad = 0;
  int edge_n = 0;
  int ready_low = 0;
  longint pix_a [NN];
  longint w_a [KK];
  longint bias_v;
  bit     relu_v;
  int     acc_q [$];
  longint got_v [2][$];
  int     got_t [2][$];
  bit     got_d [2][$];
  longint exp_v [2][$];
  int     exp_t [2][$];
  bit     exp_d [2][$];

  always @(posedge clk) edge_n <= edge_n + 1;

  // Observe away from the active edge: acceptances, outputs and o_ready lows.
  always @(negedge clk) begin
    if (en && rdy[0] && !rst) acc_q.push_back(edge_n);
    for (int d = 0; d < 2; d++) begin
      if (oen[d]) begin
        got_v[d].push_back(longint'(p[d]));
        got_t[d].push_back(edge_n);
        got_d[d].push_back(done[d]);
      end
    end
    if (!rdy[0]) ready_low <= ready_low + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    acc_q.delete();
    for (int d = 0; d < 2; d++) begin
      got_v[d].delete(); got_t[d].delete(); got_d[d].delete();
      exp_v[d].delete(); exp_t[d].delete(); exp_d[d].delete();
    end
  endtask

  task automatic set_kernel();
    longint tmp;
    for (int i = 0; i < KK; i++) begin
      tmp = w_a[i];
      weight[i*WEIGHT_W +: WEIGHT_W] = tmp[WEIGHT_W-1:0];
    end
    tmp  = bias_v;
    bias = tmp[ACC_W-1:0];
    relu = relu_v;
  endtask

  task automatic fill_const(input longint base, input longint w);
    for (int i = 0; i < NN; i++) pix_a[i] = base + longint'(i);
    for (int i = 0; i < KK; i++) w_a[i] = w;
  endtask

  task automatic fill_random();
    logic signed [DATA_W-1:0]   pv;
    logic signed [WEIGHT_W-1:0] wv;
    logic signed [ACC_W-1:0]    bv;
    for (int i = 0; i < NN; i++) begin pv = DATA_W'($urandom); pix_a[i] = pv; end
    for (int i = 0; i < KK; i++) begin wv = WEIGHT_W'($urandom); w_a[i] = wv; end
    bv = ACC_W'({$urandom, $urandom});
    bias_v = bv;
    relu_v = 1'($urandom_range(0, 1));
  endtask

  // Offer one pixel and hold it until the DUT takes it (bounded).
  task automatic drive_pixel(input longint v);
    int guard;
    guard = 0;
    en = 1'b1;
    data = v[DATA_W-1:0];
    @(negedge clk);
    while (!rdy[0] && guard < 10) begin @(negedge clk); guard++; end
    if (guard >= 10) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", rdy[0], guard);
    end
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // gap_mode 0: none, 1: one idle cycle, 2: random 0..2; scramble alters kernel mid-frame.
  task automatic send_frame(input int gap_mode, input bit scramble);
    for (int t = 0; t < NN; t++) begin
      drive_pixel(pix_a[t]);
      if (scramble && t == 0) begin
        for (int i = 0; i < KK; i++) weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'($urandom);
        bias = ACC_W'({$urandom, $urandom});
        relu = ~relu_v;
      end
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle($urandom_range(0, 2));
    end
  endtask

  // Reference: every window by its top-left corner, timed from its last pixel's accept.
  task automatic run_model(input int base);
    int s, nw, t;
    longint sum;
    logic signed [ACC_W-1:0] w48;
    for (int d = 0; d < 2; d++) begin
      s  = d + 1;
      nw = (N - K) / s + 1;
      for (int i = 0; i < nw; i++) begin
        for (int j = 0; j < nw; j++) begin
          sum = 0;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              sum += pix_a[(i*s + r)*N + j*s + c] * w_a[r*K + c];
          sum += bias_v;
          w48 = sum[ACC_W-1:0];
          sum = longint'(w48);
          if (relu_v && sum < 0) sum = 0;
          t = base + (i*s + K - 1)*N + j*s + K - 1;
          exp_v[d].push_back(sum);
          exp_t[d].push_back((t < acc_q.size()) ? acc_q[t] + 4 : -1);
          exp_d[d].push_back(i == nw - 1 && j == nw - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; data = '0; weight = '0; bias = '0; relu = 1'b0;
    idle(2);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (oen[d] !== 1'b0) begin n_bad++; $display("FAIL reset_o_en dut%0d: got %b want 0", d, oen[d]); end
      n_cmp++; if (p[d] !== '0) begin n_bad++; $display("FAIL reset_o_P dut%0d: got %0d want 0", d, p[d]); end
      n_cmp++; if (done[d] !== 1'b0) begin n_bad++; $display("FAIL reset_done dut%0d: got %b want 0", d, done[d]); end
      n_cmp++; if (rdy[d] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d: got %b want 1", d, rdy[d]); end
    end
  endtask

  task automatic test_basic();
    longint c1 [9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    longint c2 [4] = '{63, 81, 153, 171};
    fill_const(1, 1); bias_v = 0; relu_v = 1'b0;
    clear_q(); set_kernel();
    send_frame(0, 1'b0); idle(8);
    run_model(0);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got_v[d].size() != ((d == 0) ? 9 : 4)) begin
        n_bad++; $display("FAIL basic_count dut%0d: got %0d want %0d", d, got_v[d].size(), (d == 0) ? 9 : 4);
      end
      for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
        n_cmp++;
        if (got_v[d][i] !== ((d == 0) ? c1[i] : c2[i]) || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
          n_bad++;
          $display("FAIL basic dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", d, i,
                   got_v[d][i], got_t[d][i], got_d[d][i], (d == 0) ? c1[i] : c2[i], exp_t[d][i], exp_d[d][i]);
        end
      end
    end
  endtask

  task automatic test_bias_relu();
    for (int pass = 0; pass < 2; pass++) begin
      fill_const(1, (pass == 0) ? 1 : -1);
      bias_v = (pass == 0) ? -100 : 0;
      relu_v = (pass == 0);
      clear_q(); set_kernel();
      send_frame(0, 1'b0); idle(8);
      run_model(0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (got_v[d].size() != exp_v[d].size()) begin
          n_bad++; $display("FAIL bias_relu%0d_count dut%0d: got %0d want %0d", pass, d, got_v[d].size(), exp_v[d].size());
        end
        for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
          n_cmp++;
          if (got_v[d][i] !== exp_v[d][i] || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
            n_bad++;
            $display("FAIL bias_relu%0d dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", pass, d, i,
                     got_v[d][i], got_t[d][i], got_d[d][i], exp_v[d][i], exp_t[d][i], exp_d[d][i]);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    fill_const(1, 1); bias_v = 0; relu_v = 1'b0;
    clear_q(); set_kernel();
    send_frame(1, 1'b0); idle(8);
    run_model(0);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got_v[d].size() != exp_v[d].size()) begin
        n_bad++; $display("FAIL gaps_count dut%0d: got %0d want %0d", d, got_v[d].size(), exp_v[d].size());
      end
      for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
        n_cmp++;
        if (got_v[d][i] !== exp_v[d][i] || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
          n_bad++;
          $display("FAIL gaps dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", d, i,
                   got_v[d][i], got_t[d][i], got_d[d][i], exp_v[d][i], exp_t[d][i], exp_d[d][i]);
        end
      end
    end
    n_cmp++;
    if (got_t[0].size() > 1 && got_t[0][1] - got_t[0][0] != 2) begin
      n_bad++; $display("FAIL gaps_spacing: got %0d cycles want 2", got_t[0][1] - got_t[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    fill_const(1, 1); bias_v = 0; relu_v = 1'b0;
    clear_q(); set_kernel();
    for (int t = 0; t < 10; t++) drive_pixel(pix_a[t]);
    rst = 1'b1; en = 1'b1; data = DATA_W'(999);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (oen[d] !== 1'b0 || p[d] !== '0) begin n_bad++; $display("FAIL midrst_out dut%0d: got en%b P%0d want en0 P0", d, oen[d], p[d]); end
      n_cmp++; if (rdy[d] !== 1'b1) begin n_bad++; $display("FAIL midrst_ready dut%0d: got %b want 1", d, rdy[d]); end
    end
    clear_q();
    send_frame(0, 1'b0); idle(8);
    run_model(0);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got_v[d].size() != exp_v[d].size()) begin
        n_bad++; $display("FAIL midrst_count dut%0d: got %0d want %0d", d, got_v[d].size(), exp_v[d].size());
      end
      for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
        n_cmp++;
        if (got_v[d][i] !== exp_v[d][i] || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
          n_bad++;
          $display("FAIL midrst dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", d, i,
                   got_v[d][i], got_t[d][i], got_d[d][i], exp_v[d][i], exp_t[d][i], exp_d[d][i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int rl0;
    fill_random();
    clear_q(); set_kernel();
    rl0 = ready_low;
    send_frame(0, 1'b0);
    send_frame(0, 1'b0);
    idle(8);
    run_model(0);
    run_model(NN);
    n_cmp++;
    if (ready_low - rl0 != 6) begin n_bad++; $display("FAIL b2b_ready_low: got %0d cycles want 6", ready_low - rl0); end
    n_cmp++;
    if (acc_q.size() != 2*NN || acc_q[NN] - acc_q[NN-1] != 4) begin
      n_bad++; $display("FAIL b2b_restart: got %0d accepts gap %0d want %0d gap 4", acc_q.size(),
                        (acc_q.size() > NN) ? acc_q[NN] - acc_q[NN-1] : -1, 2*NN);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (got_v[d].size() != exp_v[d].size()) begin
        n_bad++; $display("FAIL b2b_count dut%0d: got %0d want %0d", d, got_v[d].size(), exp_v[d].size());
      end
      for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
        n_cmp++;
        if (got_v[d][i] !== exp_v[d][i] || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
          n_bad++;
          $display("FAIL b2b dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", d, i,
                   got_v[d][i], got_t[d][i], got_d[d][i], exp_v[d][i], exp_t[d][i], exp_d[d][i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      fill_random();
      clear_q(); set_kernel();
      send_frame(2, 1'b1); idle(8);
      run_model(0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (got_v[d].size() != exp_v[d].size()) begin
          n_bad++; $display("FAIL random%0d_count dut%0d: got %0d want %0d", f, d, got_v[d].size(), exp_v[d].size());
        end
        for (int i = 0; i < got_v[d].size() && i < exp_v[d].size(); i++) begin
          n_cmp++;
          if (got_v[d][i] !== exp_v[d][i] || got_t[d][i] !== exp_t[d][i] || got_d[d][i] !== exp_d[d][i]) begin
            n_bad++;
            $display("FAIL random%0d dut%0d out%0d: got %0d@%0d done%0b want %0d@%0d done%0b", f, d, i,
                     got_v[d][i], got_t[d][i], got_d[d][i], exp_v[d][i], exp_t[d][i], exp_d[d][i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_relu();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
